// File: rtl/mul_recon.sv
// mul_recon: iterative shift-add reconstructor, result = divisor * quotient + remainder.
// One tuple in flight, valid/ready on both sides, QWIDTH step cycles per tuple.
// Optional macro MUL_RECON_EARLY_EXIT_EN: leave CALC as soon as no quotient bits remain.
module mul_recon #(
    parameter int unsigned QWIDTH = 6,
    parameter int unsigned DWIDTH = 3,
    parameter int unsigned XWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [QWIDTH-1:0]        quotient,
    input  logic [DWIDTH-1:0]        divisor,
    input  logic [DWIDTH-1:0]        remainder,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [QWIDTH+DWIDTH-1:0] result,
    output logic                     ovf,
    output logic                     rem_err
);

    localparam int unsigned RWIDTH = QWIDTH + DWIDTH;
    localparam int unsigned CWIDTH = (QWIDTH > 1) ? $clog2(QWIDTH) : 1;
    localparam logic [CWIDTH-1:0] CntLast = CWIDTH'(QWIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e              state_q, state_d;
    logic [RWIDTH-1:0]   acc_q, acc_d;
    logic [RWIDTH-1:0]   mcand_q, mcand_d;
    logic [QWIDTH-1:0]   q_sh_q, q_sh_d;
    logic [QWIDTH-1:0]   q_next;
    logic [CWIDTH-1:0]   cnt_q, cnt_d;
    logic                rem_err_q, rem_err_d;
    logic                last_step;

    assign q_next = q_sh_q >> 1;

`ifdef MUL_RECON_EARLY_EXIT_EN
    // No set bits left after this shift means no further additions can occur.
    assign last_step = (cnt_q == CntLast) || (q_next == '0);
`else
    assign last_step = (cnt_q == CntLast);
`endif

    // State and datapath registers; async active-low reset aborts any tuple in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            mcand_q   <= '0;
            q_sh_q    <= '0;
            cnt_q     <= '0;
            rem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            q_sh_q    <= q_sh_d;
            cnt_q     <= cnt_d;
            rem_err_q <= rem_err_d;
        end
    end

    // Next-state and datapath update: load on accept, one shift-add step per CALC cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        q_sh_d    = q_sh_q;
        cnt_d     = cnt_q;
        rem_err_d = rem_err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d     = RWIDTH'(remainder);
                    mcand_d   = RWIDTH'(divisor);
                    q_sh_d    = quotient;
                    cnt_d     = '0;
                    // A zero divisor always lands here since remainder >= 0.
                    rem_err_d = (remainder >= divisor);
                    state_d   = StCalc;
                end
            end
            StCalc: begin
                if (q_sh_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                q_sh_d  = q_next;
                cnt_d   = cnt_q + CWIDTH'(1);
                if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    // acc is only reloaded on accept, so result and flags persist after handoff.
    assign result    = acc_q;
    assign rem_err   = rem_err_q;

    if (XWIDTH < RWIDTH) begin : g_ovf
        assign ovf = |acc_q[RWIDTH-1:XWIDTH];
    end else begin : g_no_ovf
        assign ovf = 1'b0;
    end

endmodule

// File: tb/tb_mul_recon.sv
// Bench for mul_recon: directed tuples, scoreboard queue checked by a negedge monitor.
module tb_mul_recon;

    localparam int unsigned QW = 6;
    localparam int unsigned DW = 3;
    localparam int unsigned XW = 8;

    typedef struct packed {
        logic [QW+DW-1:0] res;
        logic             ovf;
        logic             rem;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [QW-1:0]    quotient;
    logic [DW-1:0]    divisor;
    logic [DW-1:0]    remainder;
    logic             out_valid;
    logic             out_ready;
    logic [QW+DW-1:0] result;
    logic             ovf;
    logic             rem_err;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp;
    int   n_err;

    mul_recon #(
        .QWIDTH(QW),
        .DWIDTH(DW),
        .XWIDTH(XW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .rem_err   (rem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [QW-1:0] q);
`ifdef MUL_RECON_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < int'(QW); i++) begin
            if (q[i]) l = i + 1;
        end
        return l;
`else
        return int'(QW);
`endif
    endfunction

    // Monitor: compare every cycle the DUT presents a result; pop on the handshake.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got result %0d, expected no output", result);
            end else begin
                mon_e = sb[0];
                check("result", 32'(result), 32'(mon_e.res));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
                check("rem_err", 32'(rem_err), 32'(mon_e.rem));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Issue one tuple at posedge+1 from IDLE; returns once out_valid is seen (or bound hit).
    task automatic send(input logic [QW-1:0] q, input logic [DW-1:0] d, input logic [DW-1:0] r,
                        input int res, input logic eo, input logic er, input logic handoff);
        int lat;
        sb.push_back('{res: (QW+DW)'(res), ovf: eo, rem: er});
        quotient  = q;
        divisor   = d;
        remainder = r;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        // Scramble inputs: only the accept edge may matter.
        quotient  = ~q;
        divisor   = ~d;
        remainder = ~r;
        check("in_ready_low_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat(q)));
        check("in_ready_low_in_done", 32'(in_ready), 32'd0);
        if (handoff) begin
            @(posedge clk);
            #1;
            check("in_ready_after_handoff", 32'(in_ready), 32'd1);
            check("out_valid_after_handoff", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({ovf, rem_err}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        send(6'd37, 3'd5, 3'd3, 188, 1'b0, 1'b0, 1'b1);
        send(6'd63, 3'd7, 3'd6, 447, 1'b1, 1'b0, 1'b1);
        send(6'd10, 3'd3, 3'd3, 33, 1'b0, 1'b1, 1'b1);
        send(6'd5, 3'd0, 3'd2, 2, 1'b0, 1'b1, 1'b1);
        send(6'd63, 3'd7, 3'd7, 448, 1'b1, 1'b1, 1'b1);
        send(6'd0, 3'd7, 3'd4, 4, 1'b0, 1'b0, 1'b1);
        send(6'd1, 3'd5, 3'd0, 5, 1'b0, 1'b0, 1'b1);
        send(6'd32, 3'd3, 3'd1, 97, 1'b0, 1'b0, 1'b1);

        // Back-pressure: hold result for 5 cycles, pulse a stray in_valid meanwhile.
        out_ready = 1'b0;
        send(6'd20, 3'd4, 3'd1, 81, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                quotient  = 6'd3;
                divisor   = 3'd1;
                remainder = 3'd0;
                in_valid  = 1'b1;
            end else begin
                in_valid  = 1'b0;
            end
            @(posedge clk);
            #1;
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        send(6'd2, 3'd3, 3'd2, 8, 1'b0, 1'b0, 1'b1);

        // Reset 3 cycles into CALC: tuple is dropped, no output afterwards.
        quotient  = 6'd20;
        divisor   = 3'd4;
        remainder = 3'd1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({ovf, rem_err}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) check("abort_no_output", 32'(out_valid), 32'd0);
        end
        send(6'd1, 3'd1, 3'd0, 1, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
